// File: rtl/csrng_entropy_req_sm_pkg.sv
// Shared constants and the sparse state encoding for the CSRNG entropy requester.
package csrng_entropy_req_sm_pkg;

  localparam int StateWidth = 6;

  // Every pair of encodings differs in 4 bits, so a single flipped bit never yields another valid state.
  typedef enum logic [StateWidth-1:0] {
    Idle  = 6'b101001,
    Req   = 6'b110100,
    Hold  = 6'b000111,
    Error = 6'b011010
  } state_e;

endpackage

// File: rtl/csrng_entropy_req_timer.sv
// Request watchdog: counts cycles while enabled and emits one registered pulse when the
// count reaches a nonzero threshold, then holds. The count saturates at all-ones.
module csrng_entropy_req_timer #(
  parameter int TimeoutW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [TimeoutW-1:0] thresh_i,
  output logic                pulse_o,
  output logic [TimeoutW-1:0] cnt_o
);

  localparam logic [TimeoutW-1:0] One = TimeoutW'(1);

  logic [TimeoutW-1:0] cnt_q, cnt_d;
  logic                fired_q, fired_d;
  logic                pulse_q, pulse_d;
  logic                inc;

  // Once fired the count freezes, so a threshold raised afterwards cannot produce a second pulse.
  assign inc = en_i && !fired_q && (cnt_q != '1);

  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    pulse_d = 1'b0;
    if (clr_i) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else if (inc) begin
      cnt_d = cnt_q + One;
      if ((thresh_i != '0) && (cnt_d == thresh_i)) begin
        pulse_d = 1'b1;
        fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/prim_sparse_fsm_flop.sv
// State flop for sparse-encoded FSMs: a plain register with a synchronous reset to a
// non-zero encoding. Keeping it as a named instance gives the state a fixed hierarchy.
module prim_sparse_fsm_flop #(
  parameter int               Width      = 6,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ResetValue;
    end else begin
      state_q <= state_i;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/csrng_entropy_req_sm.sv
// CSRNG-side requester for the entropy_src seed interface: raises es_req_o, captures the
// acked seed, offers it on valid/ready, with request watchdog and terminal Error state.
module csrng_entropy_req_sm
  import csrng_entropy_req_sm_pkg::*;
#(
  parameter int DataWidth = 384,
  parameter int TimeoutW  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 seed_req_i,
  output logic                 seed_vld_o,
  input  logic                 seed_rdy_i,
  output logic [DataWidth-1:0] seed_data_o,
  output logic                 seed_fips_o,
  output logic                 es_req_o,
  input  logic                 es_ack_i,
  input  logic [DataWidth-1:0] es_bits_i,
  input  logic                 es_fips_i,
  input  logic [TimeoutW-1:0]  timeout_thresh_i,
  output logic                 timeout_o,
  output logic                 busy_o,
  input  logic                 local_escalate_i,
  output logic                 req_sm_err_o
);

  logic [StateWidth-1:0] state_q, state_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  fips_q, fips_d;
  logic                  tmr_clr;
  logic                  tmr_pulse;
  logic [TimeoutW-1:0]   tmr_cnt;

  prim_sparse_fsm_flop #(
    .Width      (StateWidth),
    .ResetValue (Idle)
  ) u_state_flop (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .state_i (state_d),
    .state_o (state_q)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    fips_d  = fips_q;
    case (state_q)
      Idle: begin
        if (enable_i && seed_req_i) state_d = Req;
      end
      Req: begin
        if (!enable_i) begin
          state_d = Idle;
        end else if (es_ack_i) begin
          state_d = Hold;
          data_d  = es_bits_i;
          fips_d  = es_fips_i;
        end
      end
      Hold: begin
        if (!enable_i || seed_rdy_i) state_d = Idle;
      end
      Error: begin
        state_d = Error;
      end
      default: begin
        state_d = Error;
      end
    endcase
    if (local_escalate_i) state_d = Error;
    // Seed material only survives while it is being offered; every other path scrubs it.
    if (state_d != Hold) begin
      data_d = '0;
      fips_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      fips_q <= 1'b0;
    end else begin
      data_q <= data_d;
      fips_q <= fips_d;
    end
  end

  // Clearing on the exit edge keeps a pulse from landing in Hold when ack and threshold coincide.
  assign tmr_clr = (state_q != Req) || (state_d != Req);

  csrng_entropy_req_timer #(
    .TimeoutW (TimeoutW)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmr_clr),
    .en_i     (state_q == Req),
    .thresh_i (timeout_thresh_i),
    .pulse_o  (tmr_pulse),
    .cnt_o    (tmr_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q != Req)) begin
      assert (tmr_cnt == '0);
    end
  end

  assign es_req_o     = (state_q == Req);
  assign seed_vld_o   = (state_q == Hold);
  assign busy_o       = (state_q == Req) || (state_q == Hold);
  assign seed_data_o  = seed_vld_o ? data_q : '0;
  assign seed_fips_o  = seed_vld_o & fips_q;
  assign timeout_o    = tmr_pulse;
  assign req_sm_err_o = (state_q != Idle) && (state_q != Req) && (state_q != Hold);

endmodule

// File: tb/tb_csrng_entropy_req_sm.sv
// Directed self-checking bench for csrng_entropy_req_sm.
module tb_csrng_entropy_req_sm;

  localparam int DW = 384;
  localparam int TW = 16;
  localparam logic [DW-1:0] PatA5 = {48{8'hA5}};
  localparam logic [DW-1:0] Pat5A = {48{8'h5A}};
  localparam logic [DW-1:0] Pat33 = {48{8'h33}};
  localparam logic [DW-1:0] Pat3C = {48{8'h3C}};

  logic          clk;
  logic          rst;
  logic          enable;
  logic          seed_req;
  logic          seed_vld;
  logic          seed_rdy;
  logic [DW-1:0] seed_data;
  logic          seed_fips;
  logic          es_req;
  logic          es_ack;
  logic [DW-1:0] es_bits;
  logic          es_fips;
  logic [TW-1:0] thresh;
  logic          timeout;
  logic          busy;
  logic          escalate;
  logic          err;

  int checks;
  int passes;

  csrng_entropy_req_sm #(.DataWidth(DW), .TimeoutW(TW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (enable),
    .seed_req_i       (seed_req),
    .seed_vld_o       (seed_vld),
    .seed_rdy_i       (seed_rdy),
    .seed_data_o      (seed_data),
    .seed_fips_o      (seed_fips),
    .es_req_o         (es_req),
    .es_ack_i         (es_ack),
    .es_bits_i        (es_bits),
    .es_fips_i        (es_fips),
    .timeout_thresh_i (thresh),
    .timeout_o        (timeout),
    .busy_o           (busy),
    .local_escalate_i (escalate),
    .req_sm_err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] seed_of(int k);
    logic [31:0] w;
    w = 32'h1234_5678 + 32'(k) * 32'h1111_1111;
    return {12{w}};
  endfunction

  // Leaves the DUT in Hold with the given seed captured.
  task automatic get_to_hold(input logic [DW-1:0] bits, input logic fips);
    enable = 1'b1; seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    es_ack = 1'b1; es_bits = bits; es_fips = fips;
    tick();
    es_ack = 1'b0; es_bits = '0; es_fips = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (es_req !== 1'b0) $display("FAIL reset_es_req: got %b want 0", es_req); else passes++;
    checks++; if (seed_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", seed_vld); else passes++;
    checks++; if (seed_data !== '0) $display("FAIL reset_data: got %h want 0", seed_data); else passes++;
    checks++; if ({busy, timeout, err, seed_fips} !== 4'b0) $display("FAIL reset_misc: got %b want 0000", {busy, timeout, err, seed_fips}); else passes++;
  endtask

  task automatic test_basic();
    enable = 1'b1; seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    checks++; if ({es_req, busy, seed_vld} !== 3'b110) $display("FAIL basic_req_entry: got %b want 110", {es_req, busy, seed_vld}); else passes++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (es_req !== 1'b1) $display("FAIL basic_req_hold[%0d]: got %b want 1", i, es_req); else passes++;
    end
    es_ack = 1'b1; es_bits = PatA5; es_fips = 1'b1;
    tick();
    es_ack = 1'b0; es_bits = '0; es_fips = 1'b0;
    checks++; if ({es_req, seed_vld, busy} !== 3'b011) $display("FAIL basic_after_ack: got %b want 011", {es_req, seed_vld, busy}); else passes++;
    checks++; if (seed_data !== PatA5) $display("FAIL basic_data: got %h want %h", seed_data, PatA5); else passes++;
    checks++; if (seed_fips !== 1'b1) $display("FAIL basic_fips: got %b want 1", seed_fips); else passes++;
    tick();
    checks++; if (seed_vld !== 1'b1 || seed_data !== PatA5) $display("FAIL basic_stable: vld %b data %h want 1 %h", seed_vld, seed_data, PatA5); else passes++;
    seed_rdy = 1'b1;
    tick();
    seed_rdy = 1'b0;
    checks++; if ({seed_vld, busy, seed_fips} !== 3'b000) $display("FAIL basic_consumed: got %b want 000", {seed_vld, busy, seed_fips}); else passes++;
    checks++; if (seed_data !== '0) $display("FAIL basic_scrub: got %h want 0", seed_data); else passes++;
  endtask

  task automatic run_timeout(input logic [TW-1:0] th, input int exp_pulses, input int exp_at);
    int pulses;
    int at;
    int req_low;
    pulses = 0; at = -1; req_low = 0;
    thresh = th;
    enable = 1'b1; seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (timeout === 1'b1) begin pulses++; at = i; end
      if (es_req !== 1'b1) req_low++;
    end
    checks++; if (pulses != exp_pulses) $display("FAIL timeout_count_th%0d: got %0d want %0d", th, pulses, exp_pulses); else passes++;
    checks++; if (at != exp_at) $display("FAIL timeout_pos_th%0d: got %0d want %0d", th, at, exp_at); else passes++;
    checks++; if (req_low != 0) $display("FAIL timeout_req_held_th%0d: low cycles %0d want 0", th, req_low); else passes++;
    es_ack = 1'b1; es_bits = Pat5A; es_fips = 1'b0;
    tick();
    es_ack = 1'b0; es_bits = '0;
    checks++; if (seed_vld !== 1'b1 || seed_data !== Pat5A || timeout !== 1'b0) $display("FAIL timeout_late_ack_th%0d: vld %b to %b data %h", th, seed_vld, timeout, seed_data); else passes++;
    seed_rdy = 1'b1;
    tick();
    seed_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    run_timeout(16'd10, 1, 10);
    run_timeout(16'd0, 0, -1);
    thresh = '0;
  endtask

  task automatic test_abort();
    enable = 1'b1; seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    tick();
    enable = 1'b0; es_ack = 1'b1; es_bits = Pat5A; es_fips = 1'b1;
    tick();
    es_ack = 1'b0; es_bits = '0; es_fips = 1'b0;
    checks++; if ({es_req, seed_vld, busy} !== 3'b000) $display("FAIL abort_req_state: got %b want 000", {es_req, seed_vld, busy}); else passes++;
    checks++; if (seed_data !== '0) $display("FAIL abort_req_data: got %h want 0", seed_data); else passes++;
    tick();
    checks++; if (seed_vld !== 1'b0) $display("FAIL abort_req_novld: got %b want 0", seed_vld); else passes++;
    get_to_hold(PatA5, 1'b1);
    enable = 1'b0;
    tick();
    checks++; if ({seed_vld, busy, seed_fips} !== 3'b000 || seed_data !== '0) $display("FAIL abort_hold: flags %b data %h want 000 0", {seed_vld, busy, seed_fips}, seed_data); else passes++;
    enable = 1'b1;
  endtask

  task automatic test_spurious();
    enable = 1'b1;
    es_ack = 1'b1; es_bits = Pat33; es_fips = 1'b1;
    tick();
    es_ack = 1'b0; es_bits = '0; es_fips = 1'b0;
    checks++; if ({es_req, busy, seed_vld} !== 3'b000 || seed_data !== '0) $display("FAIL spur_idle: flags %b data %h want 000 0", {es_req, busy, seed_vld}, seed_data); else passes++;
    get_to_hold(PatA5, 1'b1);
    es_ack = 1'b1; es_bits = Pat3C; es_fips = 1'b0;
    tick();
    es_ack = 1'b0; es_bits = '0;
    checks++; if (seed_vld !== 1'b1 || seed_data !== PatA5 || seed_fips !== 1'b1) $display("FAIL spur_hold: vld %b fips %b data %h want 1 1 %h", seed_vld, seed_fips, seed_data, PatA5); else passes++;
    seed_rdy = 1'b1;
    tick();
    seed_rdy = 1'b0;
  endtask

  task automatic test_escalate();
    get_to_hold(PatA5, 1'b1);
    escalate = 1'b1;
    tick();
    escalate = 1'b0;
    checks++; if ({err, seed_vld, busy, es_req} !== 4'b1000) $display("FAIL esc_enter: got %b want 1000", {err, seed_vld, busy, es_req}); else passes++;
    checks++; if (seed_data !== '0) $display("FAIL esc_data: got %h want 0", seed_data); else passes++;
    seed_req = 1'b1; es_ack = 1'b1; es_bits = Pat33;
    tick(); tick();
    seed_req = 1'b0; es_ack = 1'b0; es_bits = '0;
    checks++; if ({err, es_req, seed_vld} !== 3'b100) $display("FAIL esc_sticky: got %b want 100", {err, es_req, seed_vld}); else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({err, es_req, seed_vld, busy, timeout} !== 5'b0) $display("FAIL esc_reset: got %b want 00000", {err, es_req, seed_vld, busy, timeout}); else passes++;
    force dut.u_state_flop.state_q = 6'b111111;
    #1;
    checks++; if ({err, es_req, busy, seed_vld} !== 4'b1000) $display("FAIL invalid_state_now: got %b want 1000", {err, es_req, busy, seed_vld}); else passes++;
    tick();
    release dut.u_state_flop.state_q;
    tick();
    checks++; if ({err, es_req, busy} !== 3'b100) $display("FAIL invalid_state_error: got %b want 100", {err, es_req, busy}); else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (err !== 1'b0) $display("FAIL invalid_state_reset: got %b want 0", err); else passes++;
  endtask

  task automatic test_back_to_back();
    int n_rise;
    int n_seed;
    int n_ack;
    int last_rise;
    logic req_prev;
    n_rise = 0; n_seed = 0; n_ack = 0; last_rise = -1; req_prev = 1'b0;
    enable = 1'b1; seed_rdy = 1'b1; seed_req = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (es_req === 1'b1 && !req_prev) begin
        if (n_rise > 0) begin
          checks++; if (cyc - last_rise != 3) $display("FAIL b2b_spacing[%0d]: got %0d want 3", n_rise, cyc - last_rise); else passes++;
        end
        last_rise = cyc;
        n_rise++;
      end
      req_prev = es_req;
      if (seed_vld === 1'b1) begin
        checks++; if (seed_data !== seed_of(n_seed)) $display("FAIL b2b_seed[%0d]: got %h want %h", n_seed, seed_data, seed_of(n_seed)); else passes++;
        n_seed++;
      end
      es_ack = es_req;
      es_bits = seed_of(n_ack);
      if (es_req === 1'b1) n_ack++;
      if (n_ack >= 4) seed_req = 1'b0;
    end
    es_ack = 1'b0; es_bits = '0; seed_rdy = 1'b0;
    checks++; if (n_seed != 4) $display("FAIL b2b_seed_count: got %0d want 4", n_seed); else passes++;
    checks++; if (n_rise != 4) $display("FAIL b2b_req_count: got %0d want 4", n_rise); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    rst = 1'b1; enable = 1'b0; seed_req = 1'b0; seed_rdy = 1'b0;
    es_ack = 1'b0; es_bits = '0; es_fips = 1'b0; thresh = '0; escalate = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_abort();
    test_spurious();
    test_escalate();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
